xs3_digit_collector: RTL and testbench

XS3_DIGIT_COLLECTOR -- requirements
Module: xs3_digit_collector

---
 rtl/xs3_digit_collector_if.sv | 29 ++
 rtl/xs3_digit_collector.sv | 111 +++++++++++
 tb/tb_xs3_digit_collector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/xs3_digit_collector_if.sv
// Handshake bundle for xs3_digit_collector.
//   in/in_valid/in_ready    : excess-3 digit stream from the upstream encoder
//   out/out_valid/out_ready : assembled packed-BCD word to the downstream consumer
//   err/err_cnt             : illegal-code pulse and saturating illegal-code count
// master = upstream/downstream environment, slave = the collector itself.
interface xs3_digit_collector_if #(
    parameter int unsigned NDIG = 4
);
    localparam int unsigned W = 4 * NDIG;

    logic [3:0]   in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic         err;
    logic [7:0]   err_cnt;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, err, err_cnt
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, err, err_cnt
    );
endinterface

// File: rtl/xs3_digit_collector.sv
// Collects NDIG excess-3 digits into one packed-BCD word (first digit in the
// most significant nibble), then holds the word until the consumer takes it.
// Illegal codes flush the partial word, pulse err and bump a saturating count.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : xs3_digit_collector_if slave (in/in_valid/in_ready,
//           out/out_valid/out_ready, err, err_cnt)
module xs3_digit_collector #(
    parameter int unsigned NDIG = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    xs3_digit_collector_if.slave bus
);
    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned CW = 4;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic            accept_c;
    logic            legal_c;
    logic [3:0]      digit_c;

    // in_ready_q is only high in COLLECT, so accept can never coincide with release
    assign accept_c = bus.in_valid && in_ready_q;
    assign legal_c  = (bus.in >= 4'd3) && (bus.in <= 4'd12);
    assign digit_c  = bus.in - 4'd3;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            S_COLLECT: begin
                if (accept_c) begin
                    if (legal_c) begin
                        // shift form also covers NDIG=1 where the slice would be empty
                        shreg_d = (shreg_q << 4) | W'(digit_c);
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CW'(NDIG - 1)) begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        err_d   = 1'b1;
                        shreg_d = '0;
                        cnt_d   = '0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_COLLECT;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase

        in_ready_d  = (state_d == S_COLLECT);
        out_valid_d = (state_d == S_HOLD);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            shreg_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out       = shreg_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_xs3_digit_collector.sv
// Self-checking bench for xs3_digit_collector: directed scenarios followed by
// random traffic, every cycle compared against a queue-based reference model.
module tb_xs3_digit_collector;
    localparam int unsigned NDIG = 4;
    localparam int unsigned W    = 4 * NDIG;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xs3_digit_collector_if #(.NDIG(NDIG)) bus ();

    xs3_digit_collector #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: received digits in order, hold flag, error state
    int m_q[$];
    bit m_hold;
    bit m_err;
    int m_cnt;

    function automatic logic [W-1:0] m_word();
        logic [W-1:0] v;
        v = '0;
        foreach (m_q[i]) v = v * 16 + W'(m_q[i]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance, update model, compare every output
    task automatic cyc(input logic r, input logic [3:0] d, input logic v, input logic ordy);
        rst_n         = r;
        bus.in        = d;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
        if (!r) begin
            m_q.delete();
            m_hold = 0;
            m_err  = 0;
            m_cnt  = 0;
        end else begin
            m_err = 0;
            if (m_hold) begin
                if (ordy) begin
                    m_hold = 0;
                    m_q.delete();
                end
            end else if (v) begin
                if (d >= 3 && d <= 12) begin
                    m_q.push_back(int'(d) - 3);
                    if (m_q.size() == NDIG) m_hold = 1;
                end else begin
                    m_err = 1;
                    m_q.delete();
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
        chk("in_ready",  64'(bus.in_ready),  64'(!m_hold));
        chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
        chk("out",       64'(bus.out),       64'(m_word()));
        chk("err",       64'(bus.err),       64'(m_err));
        chk("err_cnt",   64'(bus.err_cnt),   64'(m_cnt));
    endtask

    task automatic dig(input logic [3:0] d);
        cyc(1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b1, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic release_word();
        cyc(1'b1, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic reset1();
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        reset1();
        reset1();
        chk("rst_out",      64'(bus.out),      64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);

        // Basic word 1234, out_ready in COLLECT ignored
        cyc(1'b1, 4'b0100, 1'b1, 1'b1);
        dig(4'b0101);
        dig(4'b0110);
        chk("partial_out", 64'(bus.out), 64'h0123);
        dig(4'b0111);
        chk("w1234_out",   64'(bus.out),       64'h1234);
        chk("w1234_valid", 64'(bus.out_valid), 64'h1);
        chk("w1234_ready", 64'(bus.in_ready),  64'h0);
        release_word();
        chk("rel_valid", 64'(bus.out_valid), 64'h0);

        // Code boundaries 0011/1100
        dig(4'b0011); dig(4'b1100); dig(4'b0011); dig(4'b1100);
        chk("w0909_out", 64'(bus.out), 64'h0909);
        release_word();
        dig(4'b0010);
        chk("err_lo_pulse", 64'(bus.err),     64'h1);
        chk("err_lo_cnt",   64'(bus.err_cnt), 64'd1);
        idle();
        chk("err_lo_clear", 64'(bus.err), 64'h0);
        dig(4'b1101);
        chk("err_hi_cnt",   64'(bus.err_cnt),   64'd2);
        chk("err_hi_valid", 64'(bus.out_valid), 64'h0);
        idle();

        // Mid-word error
        reset1();
        dig(4'b0100); dig(4'b0101); dig(4'b1111);
        dig(4'b1000); dig(4'b1001); dig(4'b1010); dig(4'b1011);
        chk("mid_out", 64'(bus.out),     64'h5678);
        chk("mid_cnt", 64'(bus.err_cnt), 64'd1);
        release_word();

        // Backpressure with in_valid asserted during HOLD
        dig(4'b0100); dig(4'b0101); dig(4'b0110); dig(4'b0111);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'b0011, 1'b1, 1'b0);
            chk("bp_out", 64'(bus.out), 64'h1234);
        end
        cyc(1'b1, 4'b0011, 1'b1, 1'b1);
        chk("bp_rel_valid", 64'(bus.out_valid), 64'h0);
        chk("bp_rel_ready", 64'(bus.in_ready),  64'h1);
        chk("bp_no_absorb", 64'(bus.out),       64'h0);
        idle();

        // Reset mid-word then fresh word
        dig(4'b0100); dig(4'b0101);
        reset1();
        chk("rmid_out", 64'(bus.out),     64'h0);
        chk("rmid_cnt", 64'(bus.err_cnt), 64'd0);
        dig(4'b1100); dig(4'b1011); dig(4'b1010); dig(4'b1001);
        chk("rmid_word", 64'(bus.out), 64'h9876);

        // Reset during HOLD, with release and accept also requested
        cyc(1'b0, 4'b0100, 1'b1, 1'b1);
        chk("rhold_valid", 64'(bus.out_valid), 64'h0);
        chk("rhold_out",   64'(bus.out),       64'h0);
        dig(4'b0011); dig(4'b0100); dig(4'b0101); dig(4'b0110);
        chk("rhold_word", 64'(bus.out), 64'h0123);
        release_word();

        // Saturation
        reset1();
        for (int i = 0; i < 260; i++) dig(4'(($urandom_range(0, 5) + 13) & 15));
        chk("sat_cnt", 64'(bus.err_cnt), 64'd255);
        chk("sat_err", 64'(bus.err),     64'h1);
        idle();
        dig(4'b1110);
        chk("sat_pulse", 64'(bus.err),     64'h1);
        chk("sat_hold",  64'(bus.err_cnt), 64'd255);

        // Random traffic
        reset1();
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 99) != 0);
            cyc(r, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
